// File: rtl/weight_ram_arbiter_pkg.sv
// weight_ram_arbiter_pkg: shared widths, weight-row addresses and FSM encoding for the weight RAM arbiter
package weight_ram_arbiter_pkg;
  localparam int DEF_AWIDTH = 4;
  localparam int DEF_DWIDTH = 256;
  localparam int DEF_LOCK_LIMIT = 2;
  localparam int WWIDTH = 8;
  localparam int LAYER1_ROW = 0;
  localparam int LAYER2_ROW = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/weight_ram_arbiter_if.sv
// weight_ram_arbiter_if: forward port (f_*), update port (u_*), RAM side (mem_*), shared rdata and busy; slave = arbiter, master = engines/RAM
interface weight_ram_arbiter_if
  import weight_ram_arbiter_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
);
  logic              f_req;
  logic [AWIDTH-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic              u_req;
  logic              u_we;
  logic [AWIDTH-1:0] u_addr;
  logic [DWIDTH-1:0] u_wdata;
  logic              u_lock;
  logic              u_gnt;
  logic              u_rvalid;
  logic [DWIDTH-1:0] rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  f_req, f_addr, u_req, u_we, u_addr, u_wdata, u_lock, mem_rdata,
    output f_gnt, f_rvalid, u_gnt, u_rvalid, rdata, mem_addr, mem_wdata, mem_we, busy
  );
  modport master (
    output f_req, f_addr, u_req, u_we, u_addr, u_wdata, u_lock, mem_rdata,
    input  f_gnt, f_rvalid, u_gnt, u_rvalid, rdata, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/weight_ram_arbiter.sv
// weight_ram_arbiter: round-robin arbiter with update-port lock for one weight RAM; ports CLK, RST, bus (weight_ram_arbiter_if.slave)
module weight_ram_arbiter
  import weight_ram_arbiter_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LOCK_LIMIT = DEF_LOCK_LIMIT
)(
  input logic CLK,
  input logic RST,
  weight_ram_arbiter_if.slave bus
);
  localparam int LW = $clog2(LOCK_LIMIT + 1);
  state_t state, state_n;
  logic own_u, last_u, txn_we, pick_u, relock, load, nxt_u;
  logic [LW-1:0] lock_cnt;
  logic [AWIDTH-1:0] addr_n;
  logic [DWIDTH-1:0] wdata_n;
  always_comb begin
    pick_u = bus.u_req && (!bus.f_req || !last_u);
    relock = state == RESP && own_u && bus.u_lock && bus.u_req && lock_cnt < LW'(LOCK_LIMIT);
    load = (state == IDLE && (bus.f_req || bus.u_req)) || relock;
    nxt_u = relock || pick_u;
    addr_n = nxt_u ? bus.u_addr : bus.f_addr;
    wdata_n = nxt_u ? bus.u_wdata : bus.mem_wdata;
    state_n = state == IDLE ? (load ? ACCESS : IDLE) : state == ACCESS ? RESP : relock ? ACCESS : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      own_u <= 1'b0;
      last_u <= 1'b1;
      txn_we <= 1'b0;
      lock_cnt <= '0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we <= 1'b0;
    end else begin
      state <= state_n;
      bus.mem_we <= load && nxt_u && bus.u_we;
      if (load) begin
        own_u <= nxt_u;
        txn_we <= nxt_u && bus.u_we;
        bus.mem_addr <= addr_n;
        bus.mem_wdata <= wdata_n;
      end
      if (load && !relock) last_u <= nxt_u;
      lock_cnt <= relock ? lock_cnt + 1'b1 : (state_n == IDLE || (load && !nxt_u)) ? '0 : lock_cnt;
    end
  end
  assign bus.f_gnt = state == ACCESS && !own_u;
  assign bus.u_gnt = state == ACCESS && own_u;
  assign bus.f_rvalid = state == RESP && !own_u && !txn_we;
  assign bus.u_rvalid = state == RESP && own_u && !txn_we;
  assign bus.rdata = bus.mem_rdata;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_weight_ram_arbiter.sv
// tb_weight_ram_arbiter: directed scoreboard bench for weight_ram_arbiter with a behavioural weight RAM
module tb_weight_ram_arbiter;
  import weight_ram_arbiter_pkg::*;
  typedef struct { bit u; logic [3:0] addr; bit we; int gap; } gnt_t;
  typedef struct { bit u; logic [255:0] data; } rd_t;
  typedef struct { logic [3:0] addr; bit we; logic [255:0] wd; bit lock; } op_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  weight_ram_arbiter_if bus ();
  weight_ram_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));
  gnt_t exp_gnt[$];
  rd_t exp_rd[$];
  op_t u_ops[$];
  logic [3:0] f_ops[$];
  int total = 0;
  int passed = 0;
  int cyc = 0;
  int last_gnt = 0;
  logic [255:0] ram [1 << DEF_AWIDTH];
  bit loaded = 1'b0;
  function automatic logic [255:0] row_init(int i);
    return 256'h0102 + 256'(i);
  endfunction
  function automatic gnt_t eg(bit u, int a, bit we, int gap);
    gnt_t g;
    g.u = u;
    g.addr = 4'(a);
    g.we = we;
    g.gap = gap;
    return g;
  endfunction
  function automatic rd_t er(bit u, logic [255:0] d);
    rd_t r;
    r.u = u;
    r.data = d;
    return r;
  endfunction
  function automatic op_t eo(int a, bit we, logic [255:0] wd, bit lock);
    op_t o;
    o.addr = 4'(a);
    o.we = we;
    o.wd = wd;
    o.lock = lock;
    return o;
  endfunction
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic fail(string name, string what);
    total++;
    $display("FAIL %s: %s", name, what);
  endtask
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < (1 << DEF_AWIDTH); i++) ram[i] <= row_init(i);
      loaded <= 1'b1;
    end else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  always @(negedge CLK) begin
    gnt_t g;
    rd_t r;
    if (bus.f_gnt || bus.u_gnt) begin
      chk("gnt_onehot", 256'(bus.f_gnt && bus.u_gnt), 256'(0));
      if (exp_gnt.size() == 0) fail("gnt_unexpected", $sformatf("got grant u=%0d addr=%0d, expected none", bus.u_gnt, bus.mem_addr));
      else begin
        g = exp_gnt.pop_front();
        chk("gnt_port", 256'(bus.u_gnt), 256'(g.u));
        chk("gnt_addr", 256'(bus.mem_addr), 256'(g.addr));
        chk("gnt_we", 256'(bus.mem_we), 256'(g.we));
        if (g.gap != 0) chk("gnt_gap", 256'(cyc - last_gnt), 256'(g.gap));
      end
      last_gnt = cyc;
    end else if (bus.mem_we) fail("mem_we_stray", "got mem_we=1 outside a grant cycle, expected 0");
    if (bus.f_rvalid || bus.u_rvalid) begin
      chk("rvalid_onehot", 256'(bus.f_rvalid && bus.u_rvalid), 256'(0));
      chk("rvalid_latency", 256'(cyc - last_gnt), 256'(1));
      if (exp_rd.size() == 0) fail("rvalid_unexpected", $sformatf("got rvalid u=%0d, expected none", bus.u_rvalid));
      else begin
        r = exp_rd.pop_front();
        chk("rvalid_port", 256'(bus.u_rvalid), 256'(r.u));
        chk("rdata", bus.rdata, r.data);
      end
    end
  end
  task automatic wait_gnt(input bit u);
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (u ? bus.u_gnt : bus.f_gnt) return;
    end
    fail(u ? "u_gnt_timeout" : "f_gnt_timeout", "got no grant within 40 cycles, expected one");
  endtask
  task automatic run_u();
    op_t o;
    while (u_ops.size() > 0) begin
      o = u_ops.pop_front();
      bus.u_req = 1'b1;
      bus.u_addr = o.addr;
      bus.u_we = o.we;
      bus.u_wdata = o.wd;
      bus.u_lock = o.lock;
      wait_gnt(1'b1);
    end
    bus.u_req = 1'b0;
    bus.u_we = 1'b0;
    bus.u_lock = 1'b0;
  endtask
  task automatic run_f();
    while (f_ops.size() > 0) begin
      bus.f_req = 1'b1;
      bus.f_addr = f_ops.pop_front();
      wait_gnt(1'b0);
    end
    bus.f_req = 1'b0;
  endtask
  task automatic run_f_late();
    @(posedge CLK);
    #1;
    run_f();
  endtask
  task automatic wait_idle();
    int quiet = 0;
    for (int n = 0; n < 200 && quiet < 3; n++) begin
      @(negedge CLK);
      quiet = bus.busy ? 0 : quiet + 1;
    end
    if (quiet < 3) fail("idle_timeout", "got busy stuck high, expected return to idle");
    @(posedge CLK);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.f_req = 1'b0;
    bus.f_addr = '0;
    bus.u_req = 1'b0;
    bus.u_we = 1'b0;
    bus.u_addr = '0;
    bus.u_wdata = '0;
    bus.u_lock = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_f_gnt", 256'(bus.f_gnt), 256'(0));
    chk("rst_u_gnt", 256'(bus.u_gnt), 256'(0));
    chk("rst_f_rvalid", 256'(bus.f_rvalid), 256'(0));
    chk("rst_u_rvalid", 256'(bus.u_rvalid), 256'(0));
    chk("rst_mem_we", 256'(bus.mem_we), 256'(0));
    chk("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
    chk("rst_mem_wdata", bus.mem_wdata, 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    RST = 1'b0;
    @(posedge CLK);
    #1;
    exp_gnt.push_back(eg(0, LAYER1_ROW, 0, 0));
    exp_rd.push_back(er(0, 256'h0102));
    f_ops.push_back(4'(LAYER1_ROW));
    run_f();
    wait_idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_gnt.push_back(eg(0, 0, 0, 0));
    exp_gnt.push_back(eg(1, 1, 0, 3));
    exp_gnt.push_back(eg(0, 0, 0, 3));
    exp_gnt.push_back(eg(1, 1, 0, 3));
    exp_rd.push_back(er(0, row_init(0)));
    exp_rd.push_back(er(1, row_init(1)));
    exp_rd.push_back(er(0, row_init(0)));
    exp_rd.push_back(er(1, row_init(1)));
    f_ops.push_back(4'd0);
    f_ops.push_back(4'd0);
    u_ops.push_back(eo(1, 0, '0, 0));
    u_ops.push_back(eo(1, 0, '0, 0));
    fork
      run_f();
      run_u();
    join
    wait_idle();
    exp_gnt.push_back(eg(1, LAYER2_ROW, 0, 0));
    exp_gnt.push_back(eg(1, LAYER2_ROW, 1, 2));
    exp_gnt.push_back(eg(0, LAYER2_ROW, 0, 3));
    exp_rd.push_back(er(1, row_init(LAYER2_ROW)));
    exp_rd.push_back(er(0, 256'hAA));
    u_ops.push_back(eo(LAYER2_ROW, 0, '0, 1));
    u_ops.push_back(eo(LAYER2_ROW, 1, 256'hAA, 1));
    f_ops.push_back(4'(LAYER2_ROW));
    fork
      run_u();
      run_f_late();
    join
    wait_idle();
    exp_gnt.push_back(eg(1, 4, 0, 0));
    exp_gnt.push_back(eg(1, 5, 0, 2));
    exp_gnt.push_back(eg(1, 6, 0, 2));
    exp_gnt.push_back(eg(0, 9, 0, 3));
    exp_gnt.push_back(eg(1, 7, 0, 3));
    exp_gnt.push_back(eg(1, 8, 0, 2));
    for (int i = 4; i <= 6; i++) exp_rd.push_back(er(1, row_init(i)));
    exp_rd.push_back(er(0, row_init(9)));
    for (int i = 7; i <= 8; i++) exp_rd.push_back(er(1, row_init(i)));
    for (int i = 4; i <= 8; i++) u_ops.push_back(eo(i, 0, '0, 1));
    f_ops.push_back(4'd9);
    fork
      run_u();
      run_f_late();
    join
    wait_idle();
    exp_gnt.push_back(eg(1, 3, 0, 0));
    exp_gnt.push_back(eg(1, 3, 0, 0));
    exp_rd.push_back(er(1, row_init(3)));
    bus.u_req = 1'b1;
    bus.u_addr = 4'd3;
    bus.u_we = 1'b0;
    bus.u_lock = 1'b0;
    wait_gnt(1'b1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_u_rvalid", 256'(bus.u_rvalid), 256'(0));
    chk("abort_f_rvalid", 256'(bus.f_rvalid), 256'(0));
    chk("abort_mem_we", 256'(bus.mem_we), 256'(0));
    chk("abort_busy", 256'(bus.busy), 256'(0));
    RST = 1'b0;
    wait_gnt(1'b1);
    bus.u_req = 1'b0;
    wait_idle();
    exp_gnt.push_back(eg(1, 2, 1, 0));
    exp_gnt.push_back(eg(0, 2, 0, 3));
    exp_rd.push_back(er(0, {256{1'b1}}));
    u_ops.push_back(eo(2, 1, {256{1'b1}}, 0));
    f_ops.push_back(4'd2);
    fork
      run_u();
      run_f_late();
    join
    wait_idle();
    exp_gnt.push_back(eg(1, 5, 0, 0));
    exp_rd.push_back(er(1, row_init(5)));
    u_ops.push_back(eo(5, 0, '0, 0));
    fork
      run_u();
      begin
        @(negedge CLK);
        @(negedge CLK);
        bus.f_req = 1'b1;
        bus.f_addr = 4'd7;
        @(negedge CLK);
        bus.f_req = 1'b0;
      end
    join
    wait_idle();
    chk("gnt_queue_drained", 256'(exp_gnt.size()), 256'(0));
    chk("rd_queue_drained", 256'(exp_rd.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
